// File: rtl/apb_reg_pkg.sv
// Shared types and address decode for the APB register file.
// The decode takes the base and register count as arguments so one function serves every instance.
package apb_reg_pkg;

  localparam int APB_DATA_W = 32;
  localparam int APB_STRB_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  // Returns 1 when addr hits a word-aligned register slot; idx is the register number.
  function automatic logic reg_decode(input  logic [31:0] addr,
                                      input  logic [31:0] base,
                                      input  int          num_regs,
                                      output logic [5:0]  idx);
    logic [31:0] off;
    off = addr - base;
    idx = 6'(off >> 2);
    return (addr >= base) && (off < 32'(4 * num_regs)) && (addr[1:0] == 2'b00);
  endfunction

endpackage

// File: rtl/apb_reg_slice.sv
// One 32-bit read/write register with byte-strobe write enable.
// Reset loads RESET_VAL; a write updates only the strobed bytes.
module apb_reg_slice
  import apb_reg_pkg::*;
#(
  parameter logic [APB_DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                  pclk,
  input  logic                  preset_n,
  input  logic                  we,
  input  logic [APB_STRB_W-1:0] strb,
  input  logic [APB_DATA_W-1:0] wdata,
  output logic [APB_DATA_W-1:0] q
);

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      q <= RESET_VAL;
    end else if (we) begin
      for (int k = 0; k < APB_STRB_W; k++) begin
        if (strb[k]) q[8*k +: 8] <= wdata[8*k +: 8];
      end
    end
  end

endmodule

// File: rtl/apb_reg_file.sv
// APB slave exposing NUM_REGS 32-bit registers, some read-only from ro_d.
// Supports programmable wait states, byte strobes and error responses.
module apb_reg_file
  import apb_reg_pkg::*;
#(
  parameter int                    ADDR_WIDTH  = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int                    NUM_REGS    = 8,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = 8'h80,
  parameter int                    WAIT_STATES = 0,
  parameter logic [31:0]           RESET_VAL   = 32'h0
) (
  input  logic                           pclk,
  input  logic                           preset_n,
  input  logic [ADDR_WIDTH-1:0]          paddr,
  input  logic                           psel,
  input  logic                           penable,
  input  logic                           pwrite,
  input  logic [APB_DATA_W-1:0]          pwdata,
  input  logic [APB_STRB_W-1:0]          pstrb,
  output logic                           pready,
  output logic [APB_DATA_W-1:0]          prdata,
  output logic                           pslverr,
  output logic [NUM_REGS*APB_DATA_W-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse,
  input  logic [NUM_REGS*APB_DATA_W-1:0] ro_d
);

  apb_state_e              state_q;
  apb_state_e              phase;
  logic [2:0]              wcnt_q;
  logic [ADDR_WIDTH-1:0]   addr_p0;
  logic                    write_p0;
  logic [APB_DATA_W-1:0]   wdata_p0;
  logic [APB_STRB_W-1:0]   strb_p0;
  logic [5:0]              idx;
  logic                    dec_ok;
  logic                    ro_hit;
  logic                    xfer_err;
  logic                    done;
  logic                    commit;
  logic [APB_DATA_W-1:0]   rd_word;
  logic [APB_DATA_W-1:0]   word_q [NUM_REGS];
  logic [NUM_REGS-1:0]     wr_pulse_p1;

  // The setup phase is recognised from the bus itself so a transfer needs only setup plus access.
  always_comb begin
    phase = state_q;
    if (state_q != ACCESS) phase = (psel && !penable) ? SETUP : IDLE;
  end

  always_comb begin
    dec_ok  = reg_decode(32'(addr_p0), 32'(BASE_ADDR), NUM_REGS, idx);
    ro_hit  = 1'b0;
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == 6'(i)) begin
        ro_hit  = RO_MASK[i];
        rd_word = word_q[i];
      end
    end
  end

  assign done     = preset_n && (phase == ACCESS) && psel && penable && (wcnt_q == 3'd0);
  assign xfer_err = !dec_ok || (write_p0 && ro_hit);
  assign commit   = done && write_p0 && !xfer_err;

  assign pready  = done;
  assign pslverr = done && xfer_err;
  assign prdata  = (done && !write_p0 && !xfer_err) ? rd_word : '0;

  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      case (phase)
        SETUP: begin
          state_q <= ACCESS;
          wcnt_q  <= 3'(WAIT_STATES);
        end
        ACCESS: begin
          if (!psel || done) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
          end else if (wcnt_q != 3'd0) begin
            wcnt_q <= wcnt_q - 3'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Setup-phase capture: the access phase works only from these copies.
  always_ff @(posedge pclk) begin
    if (phase == SETUP) begin
      addr_p0  <= paddr;
      write_p0 <= pwrite;
      wdata_p0 <= pwdata;
      strb_p0  <= pstrb;
    end
  end

  // Write pulse stage: asserted the cycle after the committing edge.
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      wr_pulse_p1 <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) wr_pulse_p1[i] <= commit && (idx == 6'(i));
    end
  end

  assign reg_wr_pulse = wr_pulse_p1;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (!RO_MASK[i]) begin : g_rw
      apb_reg_slice #(
        .RESET_VAL(RESET_VAL)
      ) u_slice (
        .pclk    (pclk),
        .preset_n(preset_n),
        .we      (commit && (idx == 6'(i))),
        .strb    (strb_p0),
        .wdata   (wdata_p0),
        .q       (word_q[i])
      );
    end else begin : g_ro
      assign word_q[i] = ro_d[32*i +: 32];
    end
    assign reg_q[32*i +: 32] = word_q[i];
  end

endmodule

// File: doc/apb_reg_file.md
APB_REG_FILE -- requirements
Module: apb_reg_file

Interface
REQ-001 Parameter ADDR_WIDTH, 10, APB address width in bits.
REQ-002 Parameter BASE_ADDR, 10'h000, byte address of register 0; must be word-aligned.
REQ-003 Parameter NUM_REGS, 8, number of 32-bit registers; range 1..64.
REQ-004 Parameter RO_MASK, 8'h80, bit i=1 makes register i read-only; it reads ro_d slice i.
REQ-005 Parameter WAIT_STATES, 0, access-phase wait cycles before pready; range 0..7.
REQ-006 Parameter RESET_VAL, 32'h0, reset value of every RW register.
REQ-007 pclk  in  1  single clock; every flop is rising-edge.
REQ-008 preset_n  in  1  reset, synchronous, active-low.
REQ-009 paddr  in  ADDR_WIDTH  APB byte address.
REQ-010 psel  in  1  APB select.
REQ-011 penable  in  1  APB access phase.
REQ-012 pwrite  in  1  1=write, 0=read.
REQ-013 pwdata  in  32  write data.
REQ-014 pstrb  in  4  byte strobes; ignored on reads.
REQ-015 pready  out  1  transfer complete.
REQ-016 prdata  out  32  read data; valid only when pready=1.
REQ-017 pslverr  out  1  error; valid only when pready=1.
REQ-018 reg_q  out  NUM_REGS*32  flattened register contents; slice i is bits [32i+31:32i].
REQ-019 reg_wr_pulse  out  NUM_REGS  one-cycle pulse on the cycle after register i is written.
REQ-020 ro_d  in  NUM_REGS*32  read-only register sources; slices of RW registers are ignored.

Function
REQ-021 FSM states are IDLE, SETUP and ACCESS.
REQ-022 IDLE -> SETUP on psel=1, penable=0.
REQ-023 SETUP: latch paddr, pwrite, pwdata and pstrb; load wait counter with WAIT_STATES; go to ACCESS.
REQ-024 ACCESS: pready=1 when psel=1, penable=1 and the counter equals 0; otherwise the counter decrements and pready=0.
REQ-025 ACCESS with pready=1 -> SETUP if psel=1 and penable=0 on the next edge, else IDLE.
REQ-026 Register index = (addr-BASE_ADDR)>>2; the decode is valid when BASE_ADDR <= addr < BASE_ADDR+4*NUM_REGS and addr[1:0]=0.
REQ-027 Error cases: invalid decode, or a write to a RO_MASK register; these give pslverr=1 with pready, no register change and no pulse.
REQ-028 Valid write commits on the pready edge; byte k is updated only if pstrb[k]=1.
REQ-029 A write with pstrb=0 changes nothing, gives pslverr=0 and still pulses reg_wr_pulse.
REQ-030 Valid read: prdata = register i (RW) or ro_d slice i (RO), sampled in the pready cycle.
REQ-031 Error read: prdata=0.
REQ-032 prdata=0 and pslverr=0 whenever pready=0.
REQ-033 Latency: write data is visible on reg_q one cycle after the pready cycle; minimum transfer is 2 cycles (setup plus access) at WAIT_STATES=0.
REQ-034 psel falling in SETUP or ACCESS before pready aborts the transfer: return to IDLE, no write, no pulse, pready stays 0.
REQ-035 penable=1 while in IDLE (no setup phase) is ignored.
REQ-036 Address, data and strobe changes during ACCESS are ignored; the latched SETUP values are used.

Reset
REQ-037 preset_n=0 at a rising edge sets: FSM=IDLE, counter=0, every RW register=RESET_VAL, reg_wr_pulse=0.
REQ-038 During reset pready=0, prdata=0 and pslverr=0.
REQ-039 Reset mid-transfer aborts the transfer with no write and no pulse.

Structure
REQ-040 Package apb_reg_pkg holds the state enum, APB_DATA_W=32, APB_STRB_W=4 and a decode function (addr -> index, valid).
REQ-041 Sub-module apb_reg_slice is one 32-bit register with byte-strobe write, write enable and reset value; it is instantiated NUM_REGS times, RW registers only.

Verification
REQ-042 Write 0x1122_3344 with pstrb=4'hF to BASE+0x4, WAIT_STATES=0: pready on the 2nd cycle, pslverr=0, reg_q[63:32]=0x1122_3344, reg_wr_pulse[1] pulses once.
REQ-043 Then write 0xAABB_CCDD with pstrb=4'b0101 to the same register: it becomes 0x11BB_33DD.
REQ-044 Set ro_d slice 7 to 0xDEAD_BEEF; read BASE+0x1C -> prdata=0xDEAD_BEEF, pslverr=0; write BASE+0x1C -> pslverr=1, no pulse.
REQ-045 Read BASE+0x20 (beyond range) and write BASE+0x2 (misaligned) -> pslverr=1, prdata=0, no register change.
REQ-046 WAIT_STATES=3: pready is 0 for 3 access cycles and 1 on the 4th; dropping psel in the 2nd wait cycle aborts the write.
REQ-047 Assert preset_n=0 during the ACCESS cycle of a write to reg 0: reg_q slice 0 = RESET_VAL and no pulse.
